// File: rtl/oled_motion_pkg.sv
// rtl/oled_motion_pkg.sv - shared OLED geometry, colours and motion state encoding
package oled_motion_pkg;

  localparam int OLED_W = 96;
  localparam int OLED_H = 64;

  localparam logic [15:0] COLOUR_BLACK = 16'h0000;
  localparam logic [15:0] COLOUR_WHITE = 16'hFFFF;
  localparam logic [15:0] COLOUR_GREEN = 16'h07E0;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_MOVE_DN  = 3'd1,
    S_DWELL_HI = 3'd2,
    S_MOVE_UP  = 3'd3,
    S_DWELL_LO = 3'd4
  } motion_state_t;

endpackage

// File: rtl/digit_motion_ctrl_if.sv
// rtl/digit_motion_ctrl_if.sv - control and anchor signals between sequencer and its host
interface digit_motion_ctrl_if;
  logic       set;
  logic       pause;
  logic       frame_start;
  logic [6:0] base_x;
  logic [6:0] base_y;
  logic       dir;
  logic       busy;
  logic       end_pulse;

  modport master (
    output set, pause, frame_start,
    input  base_x, base_y, dir, busy, end_pulse
  );

  modport slave (
    input  set, pause, frame_start,
    output base_x, base_y, dir, busy, end_pulse
  );
endinterface

// File: rtl/digit_motion_ctrl_step_prescaler.sv
// rtl/digit_motion_ctrl_step_prescaler.sv - divides clk into one-cycle motion step ticks
module step_prescaler #(
  parameter int STEP_DIV = 4000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_en,
  input  logic i_clr,
  output logic o_tick
);
  localparam int CW = $clog2(STEP_DIV);
  localparam logic [CW-1:0] LAST = CW'(STEP_DIV - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + ONE;
    end
  end

  assign o_tick = i_en && (r_cnt == LAST);
endmodule

// File: rtl/digit_motion_ctrl.sv
// rtl/digit_motion_ctrl.sv - steps the digit sprite anchor between row bounds with end dwell
// and commits the anchor row only on frame boundaries.
module digit_motion_ctrl
  import oled_motion_pkg::*;
#(
  parameter int OLED_HEIGHT  = 64,
  parameter int DIGIT_HEIGHT = 24,
  parameter int FIXED_X      = 40,
  parameter int STEP_DIV     = 4000000,
  parameter int DWELL_STEPS  = 4
) (
  input logic               clk,
  input logic               rst_n,
  digit_motion_ctrl_if.slave bus
);
  localparam logic [6:0] UB = 7'(OLED_HEIGHT - DIGIT_HEIGHT);
  localparam int DW_W = (DWELL_STEPS > 1) ? $clog2(DWELL_STEPS) : 1;
  localparam logic [DW_W-1:0] DW_LAST = DW_W'((DWELL_STEPS > 0) ? DWELL_STEPS - 1 : 0);
  localparam logic [DW_W-1:0] DW_ONE  = DW_W'(1);

  motion_state_t   r_state, w_state_nxt;
  logic [6:0]      r_pos_y, w_pos_nxt;
  logic [6:0]      r_base_y;
  logic            r_dir, w_dir_nxt;
  logic            r_end_pulse, w_end_nxt;
  logic [DW_W-1:0] r_dwell, w_dwell_nxt;
  logic            w_tick;

  step_prescaler #(.STEP_DIV(STEP_DIV)) u_prescaler (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_en   ((r_state != S_IDLE) && !bus.pause),
    .i_clr  (r_state == S_IDLE),
    .o_tick (w_tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_pos_y     <= '0;
      r_dir       <= 1'b0;
      r_end_pulse <= 1'b0;
      r_dwell     <= '0;
      r_base_y    <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_pos_y     <= w_pos_nxt;
      r_dir       <= w_dir_nxt;
      r_end_pulse <= w_end_nxt;
      r_dwell     <= w_dwell_nxt;
      // Commit samples the pre-step position so a coincident step lands next frame.
      if (bus.frame_start) r_base_y <= r_pos_y;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pos_nxt   = r_pos_y;
    w_dir_nxt   = r_dir;
    w_dwell_nxt = r_dwell;
    w_end_nxt   = 1'b0;
    if (bus.pause) begin
      w_state_nxt = r_state;
    end else if (!bus.set) begin
      // Position and direction survive so the sweep resumes where it stopped.
      w_state_nxt = S_IDLE;
      w_dwell_nxt = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_state_nxt = r_dir ? S_MOVE_UP : S_MOVE_DN;
          w_dwell_nxt = '0;
        end
        S_MOVE_DN: begin
          if (w_tick) begin
            w_pos_nxt = r_pos_y + 7'd1;
            if (w_pos_nxt == UB) begin
              w_dir_nxt   = 1'b1;
              w_end_nxt   = 1'b1;
              w_state_nxt = (DWELL_STEPS == 0) ? S_MOVE_UP : S_DWELL_HI;
            end
          end
        end
        S_DWELL_HI: begin
          if (w_tick) begin
            if (r_dwell == DW_LAST) begin
              w_dwell_nxt = '0;
              w_state_nxt = S_MOVE_UP;
            end else begin
              w_dwell_nxt = r_dwell + DW_ONE;
            end
          end
        end
        S_MOVE_UP: begin
          if (w_tick) begin
            w_pos_nxt = r_pos_y - 7'd1;
            if (w_pos_nxt == 7'd0) begin
              w_dir_nxt   = 1'b0;
              w_end_nxt   = 1'b1;
              w_state_nxt = (DWELL_STEPS == 0) ? S_MOVE_DN : S_DWELL_LO;
            end
          end
        end
        S_DWELL_LO: begin
          if (w_tick) begin
            if (r_dwell == DW_LAST) begin
              w_dwell_nxt = '0;
              w_state_nxt = S_MOVE_DN;
            end else begin
              w_dwell_nxt = r_dwell + DW_ONE;
            end
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  assign bus.base_x    = 7'(FIXED_X);
  assign bus.base_y    = r_base_y;
  assign bus.dir       = r_dir;
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.end_pulse = r_end_pulse;
endmodule

// File: tb/tb_digit_motion_ctrl.sv
// tb/tb_digit_motion_ctrl.sv - scoreboard bench for digit_motion_ctrl with dwell and no-dwell builds
module tb_digit_motion_ctrl;
  localparam int DIV = 4;
  localparam int UB  = 40;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic s = 1'b0, p = 1'b0, fs = 1'b0;

  always #5 clk = ~clk;

  digit_motion_ctrl_if bus0 ();
  digit_motion_ctrl_if bus1 ();

  assign bus0.set = s;  assign bus0.pause = p;  assign bus0.frame_start = fs;
  assign bus1.set = s;  assign bus1.pause = p;  assign bus1.frame_start = fs;

  digit_motion_ctrl #(.STEP_DIV(DIV), .DWELL_STEPS(2)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  digit_motion_ctrl #(.STEP_DIV(DIV), .DWELL_STEPS(0)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  int n_tests = 0;
  int n_fail  = 0;

  logic [16:0] q0[$];
  logic [16:0] q1[$];

  // Reference model: position, heading, elapsed cycles toward next step, dwell ticks consumed.
  int m_pos[2], m_dir[2], m_base[2], m_pre[2], m_hold[2];
  bit m_run[2], m_dwell[2];

  localparam logic [16:0] RESET_VEC = {7'd40, 7'd0, 1'b0, 1'b0, 1'b0};

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_pos[k] = 0; m_dir[k] = 0; m_base[k] = 0; m_pre[k] = 0; m_hold[k] = 0;
      m_run[k] = 0; m_dwell[k] = 0;
    end
  endtask

  task automatic model_step(input int k, input int dw, input bit si, input bit pi, input bit fi,
                            output logic [16:0] e);
    int nb;
    bit ep;
    nb = fi ? m_pos[k] : m_base[k];
    ep = 0;
    if (pi) begin
      ep = 0;
    end else if (!si) begin
      m_run[k] = 0; m_dwell[k] = 0; m_hold[k] = 0; m_pre[k] = 0;
    end else if (!m_run[k]) begin
      m_run[k] = 1; m_pre[k] = 0;
    end else begin
      m_pre[k]++;
      if (m_pre[k] == DIV) begin
        m_pre[k] = 0;
        if (m_dwell[k]) begin
          m_hold[k]++;
          if (m_hold[k] == dw) begin m_dwell[k] = 0; m_hold[k] = 0; end
        end else begin
          m_pos[k] += (m_dir[k] != 0) ? -1 : 1;
          if (m_pos[k] == ((m_dir[k] != 0) ? 0 : UB)) begin
            ep = 1;
            m_dir[k] = (m_dir[k] != 0) ? 0 : 1;
            m_dwell[k] = (dw > 0);
          end
        end
      end
    end
    m_base[k] = nb;
    e = {7'd40, 7'(m_base[k]), bit'(m_dir[k]), m_run[k], ep};
  endtask

  task automatic cyc(input bit si, input bit pi, input bit fi);
    logic [16:0] e;
    @(negedge clk);
    s = si; p = pi; fs = fi;
    model_step(0, 2, si, pi, fi, e); q0.push_back(e);
    model_step(1, 0, si, pi, fi, e); q1.push_back(e);
  endtask

  task automatic check(input string name, input int k, input logic [16:0] got, input logic [16:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d: got x=%0d y=%0d dir=%b busy=%b end=%b, expected x=%0d y=%0d dir=%b busy=%b end=%b at %0t",
               name, k, got[16:10], got[9:3], got[2], got[1], got[0],
               exp[16:10], exp[9:3], exp[2], exp[1], exp[0], $time);
    end
  endtask

  function automatic logic [16:0] obs0();
    return {bus0.base_x, bus0.base_y, bus0.dir, bus0.busy, bus0.end_pulse};
  endfunction
  function automatic logic [16:0] obs1();
    return {bus1.base_x, bus1.base_y, bus1.dir, bus1.busy, bus1.end_pulse};
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (q0.size() > 0) check("cycle", 0, obs0(), q0.pop_front());
      if (q1.size() > 0) check("cycle", 1, obs1(), q1.pop_front());
    end
  end

  task automatic run_until(input string name, input int pos, input int want_dir, input int limit);
    int n;
    n = 0;
    while (!(m_pos[0] == pos && (want_dir < 0 || m_dir[0] == want_dir) && m_run[0]) && n < limit) begin
      cyc(1'b1, 1'b0, 1'b1);
      n++;
    end
    n_tests++;
    if (n >= limit) begin
      n_fail++;
      $display("FAIL %s: pos %0d not reached within %0d cycles, model pos=%0d", name, pos, limit, m_pos[0]);
    end
  endtask

  task automatic async_reset_check(input string name);
    @(posedge clk);
    #3;
    s = 0; p = 0; fs = 0;
    rst_n = 1'b0;
    #1;
    check(name, 0, obs0(), RESET_VEC);
    check(name, 1, obs1(), RESET_VEC);
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    #1;
    check("reset", 0, obs0(), RESET_VEC);
    check("reset", 1, obs1(), RESET_VEC);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Full sweep up and back with commit every cycle.
    repeat (400) cyc(1'b1, 1'b0, 1'b1);

    // Drop run enable while moving up at 17, then resume.
    run_until("reach17up", 17, 1, 1000);
    repeat (10) cyc(1'b0, 1'b0, 1'b1);
    repeat (12) cyc(1'b1, 1'b0, 1'b1);

    // Long pause mid-step at 5.
    run_until("reach5", 5, -1, 1000);
    cyc(1'b1, 1'b0, 1'b1);
    repeat (20) cyc(1'b1, 1'b1, ($urandom_range(0, 1) == 1));
    repeat (12) cyc(1'b1, 1'b0, 1'b1);

    // No commits while the position advances, then a single commit.
    repeat (20) cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b1);

    repeat (2500) cyc(($urandom_range(0, 19) != 0), ($urandom_range(0, 7) == 0), ($urandom_range(0, 2) == 0));

    run_until("reach30", 30, -1, 1000);
    async_reset_check("async_reset");

    repeat (500) cyc(($urandom_range(0, 29) != 0), ($urandom_range(0, 9) == 0), ($urandom_range(0, 1) == 0));

    @(posedge clk);
    #3;
    n_tests++;
    if (q0.size() != 0 || q1.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d/%0d pending, expected 0/0", q0.size(), q1.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
